// File: rtl/unified_mem_arbiter.sv
// Shares one single-port word memory between fetch and data; data wins unless fetch has lost MAX_DSTREAK contended cycles.
// Same-cycle ready with no buffering (a denied requester holds its request); read response one cycle after accept.
module unified_mem_arbiter #(
  parameter int AW          = 12,
  parameter int MAX_DSTREAK = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ready,
  output logic          if_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_wstrb,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_ready,
  output logic          d_rvalid,
  output logic          mem_en,
  output logic [3:0]    mem_wstrb,
  output logic [AW-3:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [15:0]   conflict_cnt
);

  localparam int            SW         = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  typedef enum logic [1:0] {
    RSP_NONE = 2'b00,
    RSP_IF   = 2'b01,
    RSP_D    = 2'b10
  } rsp_e;

  logic [SW-1:0] streak_q;
  rsp_e          rsp_q;
  rsp_e          rsp_d;
  logic          grant_if;
  logic          grant_d;
  logic          streak_full;

  assign streak_full = (streak_q == STREAK_MAX);

  // No grants at all while reset is held, even though requests may be up.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (reset_n) begin
      if (if_req && (!d_req || streak_full)) begin
        grant_if = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end
    end
  end

  // Counts only data wins that actually cost fetch a cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      streak_q <= '0;
    end else if (grant_if) begin
      streak_q <= '0;
    end else if (grant_d && if_req) begin
      streak_q <= streak_q + SW'(1);
    end
  end

  always_comb begin
    rsp_d = RSP_NONE;
    if (grant_if) begin
      rsp_d = RSP_IF;
    end else if (grant_d && !d_we) begin
      rsp_d = RSP_D;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_q <= RSP_NONE;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  assign if_rvalid = (rsp_q == RSP_IF);
  assign d_rvalid  = (rsp_q == RSP_D);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conflict_cnt <= '0;
    end else if (if_req && !grant_if && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  assign if_ready  = grant_if;
  assign d_ready   = grant_d;
  assign mem_en    = grant_if | grant_d;
  assign mem_addr  = grant_d ? d_addr[AW-1:2] : if_addr[AW-1:2];
  assign mem_wstrb = (grant_d && d_we) ? d_wstrb : 4'b0000;
  assign mem_wdata = d_wdata;

  // Requesters tap memory read data directly; this block only qualifies it with rvalid.
  logic unused_inputs;
  assign unused_inputs = ^{if_addr[1:0], d_addr[1:0], mem_rdata};

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed vectors, a memory behind the arbiter, and a cycle model.
module tb_unified_mem_arbiter;

  localparam int AW   = 12;
  localparam int MAXD = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ready;
  logic          if_rvalid;
  logic          d_req;
  logic          d_we;
  logic [3:0]    d_wstrb;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_ready;
  logic          d_rvalid;
  logic          mem_en;
  logic [3:0]    mem_wstrb;
  logic [AW-3:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [15:0]   conflict_cnt;

  logic          rst2_n;
  logic [15:0]   sat_cnt;
  logic          unused_if_ready, unused_if_rvalid, unused_d_ready, unused_d_rvalid, unused_mem_en;
  logic [3:0]    unused_wstrb;
  logic [AW-3:0] unused_maddr;
  logic [31:0]   unused_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.AW(AW), .MAX_DSTREAK(MAXD)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rvalid(if_rvalid),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid),
    .mem_en(mem_en), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  unified_mem_arbiter #(.AW(AW), .MAX_DSTREAK(65535)) u_sat (
    .clk(clk), .reset_n(rst2_n),
    .if_req(1'b1), .if_addr(12'h000), .if_ready(unused_if_ready), .if_rvalid(unused_if_rvalid),
    .d_req(1'b1), .d_we(1'b0), .d_wstrb(4'h0), .d_addr(12'h000), .d_wdata(32'h0),
    .d_ready(unused_d_ready), .d_rvalid(unused_d_rvalid),
    .mem_en(unused_mem_en), .mem_wstrb(unused_wstrb), .mem_addr(unused_maddr), .mem_wdata(unused_wdata),
    .mem_rdata(32'h0), .conflict_cnt(sat_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'h11223344 : {16'hA5A5, 16'(i)};
  endfunction

  // Memory macro stand-in: samples the granted access mid-cycle, performs it on the edge.
  logic [31:0] envmem [1024];
  initial begin : env_mem
    logic          cap_en;
    logic [3:0]    cap_wstrb;
    logic [AW-3:0] cap_addr;
    logic [31:0]   cap_wdata;
    for (int i = 0; i < 1024; i++) envmem[i] = init_word(i);
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      cap_en = mem_en; cap_wstrb = mem_wstrb; cap_addr = mem_addr; cap_wdata = mem_wdata;
      @(posedge clk);
      if (cap_en && reset_n) begin
        if (cap_wstrb != 4'h0) begin
          for (int b = 0; b < 4; b++)
            if (cap_wstrb[b]) envmem[cap_addr][8*b +: 8] = cap_wdata[8*b +: 8];
        end else begin
          mem_rdata = envmem[cap_addr];
        end
      end
    end
  end

  // Reference model: who wins, what is owed back next cycle, how many fetch losses so far.
  int          m_run  = 0;  // contended data wins since fetch last got through
  int          m_conf = 0;
  int          m_pend = 0;  // 0 nothing owed, 1 fetch owed, 2 data owed
  logic [31:0] m_pdata = 32'h0;
  logic [31:0] shadow [1024];

  always @(negedge reset_n) begin
    m_run  = 0;
    m_conf = 0;
    m_pend = 0;
  end

  initial begin : model
    int          g;
    int          n_run, n_conf, n_pend;
    logic [31:0] n_pdata;
    logic        do_wr;
    logic [9:0]  wr_addr;
    logic [3:0]  wr_strb;
    logic [31:0] wr_dat;
    for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (!reset_n)                g = 0;
      else if (if_req && d_req)    g = (m_run >= MAXD) ? 1 : 2;
      else if (if_req)             g = 1;
      else if (d_req)              g = 2;
      else                         g = 0;

      chk("if_ready", 32'(if_ready), 32'(g == 1));
      chk("d_ready", 32'(d_ready), 32'(g == 2));
      chk("mem_en", 32'(mem_en), 32'(g != 0));
      if (g == 1) chk("mem_addr_if", 32'(mem_addr), 32'(if_addr >> 2));
      if (g == 2) chk("mem_addr_d", 32'(mem_addr), 32'(d_addr >> 2));
      chk("mem_wstrb", 32'(mem_wstrb), (g == 2 && d_we) ? 32'(d_wstrb) : 32'd0);
      chk("mem_wdata", mem_wdata, d_wdata);
      chk("if_rvalid", 32'(if_rvalid), 32'(m_pend == 1));
      chk("d_rvalid", 32'(d_rvalid), 32'(m_pend == 2));
      if (m_pend != 0) chk("rdata", mem_rdata, m_pdata);
      chk("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));

      n_run = (g == 1) ? 0 : ((g == 2 && if_req) ? m_run + 1 : m_run);
      n_conf = (if_req && g != 1 && m_conf < 65535) ? m_conf + 1 : m_conf;
      n_pend = 0;
      n_pdata = 32'h0;
      do_wr = 1'b0;
      wr_addr = d_addr[AW-1:2];
      wr_strb = d_wstrb;
      wr_dat = d_wdata;
      if (g == 1) begin
        n_pend = 1; n_pdata = shadow[if_addr[AW-1:2]];
      end else if (g == 2 && !d_we) begin
        n_pend = 2; n_pdata = shadow[d_addr[AW-1:2]];
      end else if (g == 2) begin
        do_wr = 1'b1;
      end

      @(posedge clk);
      if (reset_n) begin
        m_run = n_run; m_conf = n_conf; m_pend = n_pend; m_pdata = n_pdata;
        if (do_wr)
          for (int b = 0; b < 4; b++)
            if (wr_strb[b]) shadow[wr_addr][8*b +: 8] = wr_dat[8*b +: 8];
      end
    end
  end

  typedef struct packed {
    logic        ir;
    logic [11:0] ia;
    logic        dr;
    logic        dw;
    logic [3:0]  ds;
    logic [11:0] da;
    logic [31:0] dd;
  } vec_t;

  vec_t vecs [7] = '{
    '{1'b1, 12'h040, 1'b1, 1'b1, 4'hF, 12'h044, 32'hCAFEF00D},
    '{1'b1, 12'h040, 1'b1, 1'b0, 4'h0, 12'h044, 32'h0},
    '{1'b1, 12'h040, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0},
    '{1'b0, 12'h000, 1'b1, 1'b1, 4'h8, 12'h048, 32'h77000000},
    '{1'b1, 12'h044, 1'b1, 1'b0, 4'h0, 12'h048, 32'h0},
    '{1'b1, 12'h044, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0},
    '{1'b0, 12'h000, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0}
  };

  logic [31:0] exp_f [3] = '{32'hA5A50000, 32'hA5A50001, 32'hA5A50002};
  logic [9:0]  dpat = 10'b0111101111;  // bit i: data wins cycle i of contention

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'h0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin : main
    reset_n = 1'b1; rst2_n = 1'b1;
    idle(); if_addr = '0; d_addr = '0; d_wdata = '0;
    #1;
    reset_n = 1'b0; rst2_n = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    repeat (3) tick();

    // Held in reset with both requests up: nothing granted.
    @(negedge clk);
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    chk("rst_d_ready", 32'(d_ready), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_rvalid", 32'({if_rvalid, d_rvalid}), 32'd0);
    chk("rst_conflict", 32'(conflict_cnt), 32'd0);

    // Release reset and stream fetches 0x0, 0x4, 0x8.
    @(posedge clk); #1;
    reset_n = 1'b1; d_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if_addr = 12'(4 * k);
      @(negedge clk);
      chk("fetch_ready", 32'(if_ready), 32'd1);
      chk("fetch_mem_addr", 32'(mem_addr), k);
      if (k > 0) begin
        chk("fetch_rvalid", 32'(if_rvalid), 32'd1);
        chk("fetch_rdata", mem_rdata, exp_f[k-1]);
      end
      tick();
    end
    idle();
    @(negedge clk);
    chk("fetch_rvalid_last", 32'(if_rvalid), 32'd1);
    chk("fetch_rdata_last", mem_rdata, exp_f[2]);
    tick();
    @(negedge clk);
    chk("fetch_rvalid_done", 32'(if_rvalid), 32'd0);
    tick();

    // Contention for 10 cycles.
    do_reset();
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 12'h020; if_addr = 12'h030;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("contend_d_ready", 32'(d_ready), 32'(dpat[i]));
      chk("contend_if_ready", 32'(if_ready), 32'(!dpat[i]));
      tick();
    end
    idle();
    @(negedge clk);
    chk("contend_conflict", 32'(conflict_cnt), 32'd8);
    tick();

    // Partial write then read of the same word.
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'h3; d_addr = 12'h010; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_ready", 32'(d_ready), 32'd1);
    chk("wr_strb", 32'(mem_wstrb), 32'h3);
    tick();
    d_we = 1'b0; d_wstrb = 4'h0;
    @(negedge clk);
    chk("rd_ready", 32'(d_ready), 32'd1);
    chk("wr_no_rvalid", 32'(d_rvalid), 32'd0);
    tick();
    idle();
    @(negedge clk);
    chk("rd_rvalid", 32'(d_rvalid), 32'd1);
    chk("rd_merged", mem_rdata, 32'h1122BEEF);
    chk("rd_if_quiet", 32'(if_rvalid), 32'd0);
    tick();

    // Reset pulse while a data read response is owed.
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 12'h010;
    @(negedge clk);
    chk("midrst_accept", 32'(d_ready), 32'd1);
    @(posedge clk); #1;
    idle();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_rvalid", 32'(d_rvalid), 32'd0);
      chk("midrst_conflict", 32'(conflict_cnt), 32'd0);
      tick();
    end

    // Mixed directed vectors, checked cycle by cycle by the model.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if_req = vecs[i].ir; if_addr = vecs[i].ia;
      d_req = vecs[i].dr; d_we = vecs[i].dw; d_wstrb = vecs[i].ds;
      d_addr = vecs[i].da; d_wdata = vecs[i].dd;
      @(negedge clk);
      if (i == 5) chk("vec_d_rdata", mem_rdata, 32'h77A50012);
      if (i == 6) chk("vec_if_rdata", mem_rdata, 32'hCAFEF00D);
      tick();
    end
    idle();

    // Saturating conflict counter on the long-streak instance.
    rst2_n = 1'b1;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk("sat_before", 32'(sat_cnt), 32'h0000FFFE);
    repeat (11) @(posedge clk);
    @(negedge clk);
    chk("sat_hold", 32'(sat_cnt), 32'h0000FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
